// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - commit stream and trace drain bundle; trace_cycle present when TRACE_TIMESTAMP_EN is defined
interface commit_trace_buffer_if;
    logic        pipeline_commit_wr;
    logic [4:0]  pipeline_commit_wr_idx;
    logic [31:0] pipeline_commit_wr_data;
    logic [31:0] pipeline_commit_NPC;
    logic        mem_wb_valid_inst;
    logic [31:0] mem_wb_IR;
    logic        trace_ready;
    logic        trace_valid;
    logic [4:0]  trace_idx;
    logic [31:0] trace_data;
    logic [31:0] trace_npc;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] trace_cycle;
`endif

    modport master (
        output pipeline_commit_wr, pipeline_commit_wr_idx, pipeline_commit_wr_data,
        output pipeline_commit_NPC, mem_wb_valid_inst, mem_wb_IR, trace_ready,
`ifdef TRACE_TIMESTAMP_EN
        input  trace_cycle,
`endif
        input  trace_valid, trace_idx, trace_data, trace_npc
    );

    modport slave (
        input  pipeline_commit_wr, pipeline_commit_wr_idx, pipeline_commit_wr_data,
        input  pipeline_commit_NPC, mem_wb_valid_inst, mem_wb_IR, trace_ready,
`ifdef TRACE_TIMESTAMP_EN
        output trace_cycle,
`endif
        output trace_valid, trace_idx, trace_data, trace_npc
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - register-write commit trace FIFO with retire/cycle counters and halt detection
// Optional TRACE_TIMESTAMP_EN adds the push-time cycle_count to each entry (trace_cycle).
module commit_trace_buffer #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] HALT_IR = 32'h00000073
) (
    input  logic                       clk,
    input  logic                       rst,
    commit_trace_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [31:0]                commit_count,
    output logic [31:0]                cycle_count,
    output logic [15:0]                dropped_count,
    output logic                       overflow,
    output logic                       halted,
    output logic                       done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 101;
`else
    localparam int ENTRY_W = 69;
`endif

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        commit_q, commit_d;
    logic [31:0]        cycle_q, cycle_d;
    logic [15:0]        dropped_q, dropped_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    logic run, push_req, pop, full, do_push, drop;

    assign run      = (state_q == ST_RUN);
    assign push_req = run && bus.pipeline_commit_wr && (bus.pipeline_commit_wr_idx != 5'd0);
    assign pop      = (count_q != '0) && bus.trace_ready;
    assign full     = (count_q == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
    assign wr_entry = {cycle_q, bus.pipeline_commit_wr_idx, bus.pipeline_commit_wr_data, bus.pipeline_commit_NPC};
    assign bus.trace_cycle = rd_entry[100:69];
`else
    assign wr_entry = {bus.pipeline_commit_wr_idx, bus.pipeline_commit_wr_data, bus.pipeline_commit_NPC};
`endif

    assign rd_entry      = mem_q[rd_ptr_q];
    assign bus.trace_idx  = rd_entry[68:64];
    assign bus.trace_data = rd_entry[63:32];
    assign bus.trace_npc  = rd_entry[31:0];
    assign bus.trace_valid = (count_q != '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        commit_d   = commit_q;
        cycle_d    = cycle_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (!do_push && pop) count_d = count_q - 1'b1;

        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end

        case (state_q)
            ST_RUN: begin
                cycle_d = cycle_q + 32'd1;
                if (bus.mem_wb_valid_inst) begin
                    commit_d = commit_q + 32'd1;
                    if (bus.mem_wb_IR == HALT_IR) state_d = ST_HALTED;
                end
            end
            ST_HALTED: if (count_q == '0) state_d = ST_DONE;
            default:   state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            commit_q   <= '0;
            cycle_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            commit_q   <= commit_d;
            cycle_q    <= cycle_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign fifo_count    = count_q;
    assign commit_count  = commit_q;
    assign cycle_count   = cycle_q;
    assign dropped_count = dropped_q;
    assign overflow      = overflow_q;
    assign halted        = (state_q != ST_RUN);
    assign done          = (state_q == ST_DONE);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  fifo_count;
    logic [31:0] commit_count, cycle_count;
    logic [15:0] dropped_count;
    logic        overflow, halted, done;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    commit_trace_buffer_if bus ();

    commit_trace_buffer #(.DEPTH(16), .HALT_IR(32'h00000073)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fifo_count(fifo_count), .commit_count(commit_count), .cycle_count(cycle_count),
        .dropped_count(dropped_count), .overflow(overflow), .halted(halted), .done(done)
    );

    task automatic drive(input logic wr, input logic [4:0] idx, input logic [31:0] data,
                         input logic [31:0] npc, input logic vld, input logic [31:0] ir);
        bus.pipeline_commit_wr      = wr;
        bus.pipeline_commit_wr_idx  = idx;
        bus.pipeline_commit_wr_data = data;
        bus.pipeline_commit_NPC     = npc;
        bus.mem_wb_valid_inst       = vld;
        bus.mem_wb_IR               = ir;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'h00000013);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        bus.trace_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.trace_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (trace_valid_q() !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.trace_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (commit_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", commit_count, cycle_count); end
        checks++; if (dropped_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_drop got=%0d/%0b exp=0/0", dropped_count, overflow); end
        checks++; if (halted !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_state got=%0b/%0b exp=0/0", halted, done); end
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL run_cycles got=%0d exp=3", cycle_count); end
    endtask

    function automatic logic trace_valid_q();
        return bus.trace_valid;
    endfunction

    task automatic test_passthrough();
        logic [4:0]  e_idx [3];
        logic [31:0] e_dat [3];
        logic [31:0] e_npc [3];
        e_idx = '{5'd1, 5'd2, 5'd3};
        e_dat = '{32'h11, 32'h22, 32'h33};
        e_npc = '{32'h4, 32'h8, 32'hC};
        do_reset();
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, e_idx[i], e_dat[i], e_npc[i], 1'b1, 32'h00000013);
            tick();
            checks++;
            if (bus.trace_valid !== 1'b1 || fifo_count !== 5'd1 || bus.trace_idx !== e_idx[i] ||
                bus.trace_data !== e_dat[i] || bus.trace_npc !== e_npc[i]) begin
                errors++;
                $display("FAIL pass_%0d got v=%0b n=%0d (%0d,%h,%h) exp v=1 n=1 (%0d,%h,%h)", i, bus.trace_valid,
                         fifo_count, bus.trace_idx, bus.trace_data, bus.trace_npc, e_idx[i], e_dat[i], e_npc[i]);
            end
        end
        idle();
        tick();
        checks++; if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got n=%0d v=%0b exp 0/0", fifo_count, bus.trace_valid); end
        checks++; if (commit_count !== 32'd3) begin errors++; $display("FAIL pass_commits got=%0d exp=3", commit_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'(4 * i), 1'b1, 32'h00000013);
            tick();
        end
        idle();
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", fifo_count); end
        checks++; if (overflow !== 1'b1 || dropped_count !== 16'd1) begin errors++; $display("FAIL ovf_flags got=%0b/%0d exp=1/1", overflow, dropped_count); end
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.trace_valid !== 1'b1 || bus.trace_idx !== 5'(i + 1) || bus.trace_data !== 32'h100 + 32'(i) ||
                bus.trace_npc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d got (%0d,%h,%h) exp (%0d,%h,%h)", i, bus.trace_idx, bus.trace_data,
                         bus.trace_npc, i + 1, 32'h100 + 32'(i), 32'(4 * i));
            end
            tick();
        end
        checks++; if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got n=%0d v=%0b exp 0/0", fifo_count, bus.trace_valid); end
        bus.trace_ready = 1'b0;
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b1, 5'd0, 32'hDEAD, 32'h10, 1'b1, 32'h00000013);
        tick();
        idle();
        checks++; if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0) begin errors++; $display("FAIL x0_push got n=%0d v=%0b exp 0/0", fifo_count, bus.trace_valid); end
        checks++; if (commit_count !== 32'd1) begin errors++; $display("FAIL x0_commit got=%0d exp=1", commit_count); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'd9, 32'h200 + 32'(i), 32'h0, 1'b1, 32'h00000013);
            tick();
        end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", fifo_count); end
        drive(1'b1, 5'd7, 32'hABC, 32'h44, 1'b1, 32'h00000013);
        bus.trace_ready = 1'b1;
        checks++; if (bus.trace_data !== 32'h200) begin errors++; $display("FAIL full_oldest got=%h exp=200", bus.trace_data); end
        tick();
        idle();
        checks++; if (fifo_count !== 5'd16 || overflow !== 1'b0 || dropped_count !== 16'd0) begin
            errors++; $display("FAIL full_pushpop got n=%0d o=%0b d=%0d exp 16/0/0", fifo_count, overflow, dropped_count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.trace_data !== ((i == 15) ? 32'hABC : 32'h201 + 32'(i))) begin
                errors++;
                $display("FAIL full_drain_%0d got=%h exp=%h", i, bus.trace_data, (i == 15) ? 32'hABC : 32'h201 + 32'(i));
            end
            tick();
        end
        bus.trace_ready = 1'b0;
    endtask

    task automatic test_halt();
        int waited;
        do_reset();
        drive(1'b1, 5'd5, 32'h55, 32'h40, 1'b1, 32'h00000073);
        tick();
        checks++; if (halted !== 1'b1 || done !== 1'b0 || fifo_count !== 5'd1) begin
            errors++; $display("FAIL halt_enter got h=%0b d=%0b n=%0d exp 1/0/1", halted, done, fifo_count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(6 + i), 32'h66 + 32'(i), 32'h44, 1'b1, 32'h00000013);
            tick();
        end
        idle();
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL halt_nopush got=%0d exp=1", fifo_count); end
        checks++; if (cycle_count !== 32'd1 || commit_count !== 32'd1) begin
            errors++; $display("FAIL halt_frozen got c=%0d r=%0d exp 1/1", cycle_count, commit_count); end
        checks++; if (bus.trace_idx !== 5'd5 || bus.trace_data !== 32'h55 || bus.trace_npc !== 32'h40) begin
            errors++; $display("FAIL halt_entry got (%0d,%h,%h) exp (5,55,40)", bus.trace_idx, bus.trace_data, bus.trace_npc); end
        bus.trace_ready = 1'b1;
        tick();
        checks++; if (fifo_count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL halt_pop got n=%0d d=%0b exp 0/0", fifo_count, done); end
        waited = 0;
        while (done !== 1'b1 && waited < 4) begin tick(); waited++; end
        checks++; if (done !== 1'b1 || waited !== 1) begin errors++; $display("FAIL halt_done got d=%0b after %0d cycles exp 1 after 1", done, waited); end
        bus.trace_ready = 1'b0;
    endtask

    task automatic test_halt_empty();
        do_reset();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h00000073);
        tick();
        idle();
        checks++; if (halted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hempty_1 got h=%0b d=%0b exp 1/0", halted, done); end
        tick();
        checks++; if (halted !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL hempty_2 got h=%0b d=%0b exp 1/1", halted, done); end
    endtask

    initial begin
        rst = 1'b1;
        bus.trace_ready = 1'b0;
        idle();
        test_reset();
        test_passthrough();
        test_overflow();
        test_x0();
        test_full_push_pop();
        test_halt();
        test_halt_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
